// File: rtl/bnn_layer_sequencer_if.sv
// Host-side handshake bundle for bnn_layer_sequencer.
//   cfg_*    : configuration byte stream (valid/ready) plus start/done.
//   infer_*  : input-vector stream (valid/ready).
//   result*  : captured axons and their one-cycle valid pulse.
// master = host, slave = sequencer.
interface bnn_layer_sequencer_if #(
  parameter int NEURONS = 4
);
  logic               cfg_start;
  logic [7:0]         cfg_data;
  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_done;
  logic [7:0]         infer_data;
  logic               infer_valid;
  logic               infer_ready;
  logic [NEURONS-1:0] result;
  logic               result_valid;

  modport master (
    output cfg_start, cfg_data, cfg_valid, infer_data, infer_valid,
    input  cfg_ready, cfg_done, infer_ready, result, result_valid
  );

  modport slave (
    input  cfg_start, cfg_data, cfg_valid, infer_data, infer_valid,
    output cfg_ready, cfg_done, infer_ready, result, result_valid
  );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Sequencer for a daisy-chained layer of binary neurons (8-bit weights +
// 3-bit bias each, NEURONS*11 parameter bits in total).
//   CONFIG : bytes accepted on bus.cfg_* are shifted MSB-first onto
//            o_param_in with o_setup high, exactly NEURONS*11 cycles total.
//   INFER  : vectors accepted on bus.infer_* drive o_inputs_out; SETTLE
//            cycles later i_axons is captured into bus.result with a
//            one-cycle bus.result_valid pulse.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus           host handshake bundle (slave side)
//   o_setup       shift enable to every neuron
//   o_param_in    serial parameter bit into the first neuron
//   o_inputs_out  registered input vector to every neuron
//   i_axons       neuron outputs, bit k = neuron k
//   o_busy        high outside IDLE/READY
module bnn_layer_sequencer #(
  parameter int NEURONS = 4,
  parameter int SETTLE  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bnn_layer_sequencer_if.slave   bus,
  output logic                   o_setup,
  output logic                   o_param_in,
  output logic [7:0]             o_inputs_out,
  input  logic [NEURONS-1:0]     i_axons,
  output logic                   o_busy
);
  localparam int TOTAL_BITS = NEURONS * 11;
  localparam int BW         = $clog2(TOTAL_BITS + 1);
  localparam int CW         = $clog2(SETTLE + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(TOTAL_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_READY, S_SETTLE_W
  } state_t;

  state_t             r_state;
  logic [BW-1:0]      r_bit_cnt;
  logic [3:0]         r_byte_bits;
  logic [7:0]         r_shreg;
  logic [CW-1:0]      r_cnt;
  logic               r_cfg_ready, r_cfg_done, r_setup, r_param_in;
  logic               r_infer_ready, r_result_valid, r_busy;
  logic [7:0]         r_inputs_out;
  logic [NEURONS-1:0] r_result;

  // Every output is a register updated together with the state it belongs to,
  // so each one reflects the state the FSM is in during that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_bit_cnt      <= '0;
      r_byte_bits    <= '0;
      r_shreg        <= '0;
      r_cnt          <= '0;
      r_cfg_ready    <= 1'b0;
      r_cfg_done     <= 1'b0;
      r_setup        <= 1'b0;
      r_param_in     <= 1'b0;
      r_infer_ready  <= 1'b0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_inputs_out   <= '0;
      r_result       <= '0;
    end else if (bus.cfg_start) begin
      // Restart wins over any handshake; an in-flight inference is dropped.
      r_state        <= S_LOAD;
      r_bit_cnt      <= '0;
      r_cfg_ready    <= 1'b1;
      r_cfg_done     <= 1'b0;
      r_setup        <= 1'b0;
      r_param_in     <= 1'b0;
      r_infer_ready  <= 1'b0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b1;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: ;
        S_LOAD: begin
          if (bus.cfg_valid) begin
            // The MSB goes on the wire in the first SHIFT cycle.
            r_state     <= S_SHIFT;
            r_cfg_ready <= 1'b0;
            r_param_in  <= bus.cfg_data[7];
            r_shreg     <= {bus.cfg_data[6:0], 1'b0};
            r_setup     <= 1'b1;
            r_byte_bits <= '0;
          end
        end
        S_SHIFT: begin
          r_bit_cnt   <= r_bit_cnt + 1'b1;
          r_byte_bits <= r_byte_bits + 1'b1;
          // Chain-full check first: when the total is a multiple of 8 the
          // last bit of the stream is also the last bit of a byte.
          if (r_bit_cnt == LAST_BIT) begin
            r_state       <= S_READY;
            r_setup       <= 1'b0;
            r_param_in    <= 1'b0;
            r_cfg_done    <= 1'b1;
            r_infer_ready <= 1'b1;
            r_busy        <= 1'b0;
          end else if (r_byte_bits == 4'd7) begin
            r_state     <= S_LOAD;
            r_setup     <= 1'b0;
            r_param_in  <= 1'b0;
            r_cfg_ready <= 1'b1;
          end else begin
            r_param_in <= r_shreg[7];
            r_shreg    <= {r_shreg[6:0], 1'b0};
          end
        end
        S_READY: begin
          if (bus.infer_valid) begin
            r_state       <= S_SETTLE_W;
            r_inputs_out  <= bus.infer_data;
            r_cnt         <= CW'(SETTLE);
            r_infer_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_SETTLE_W: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state        <= S_READY;
            r_result       <= i_axons;
            r_result_valid <= 1'b1;
            r_infer_ready  <= 1'b1;
            r_busy         <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready    = r_cfg_ready;
  assign bus.cfg_done     = r_cfg_done;
  assign bus.infer_ready  = r_infer_ready;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign o_setup          = r_setup;
  assign o_param_in       = r_param_in;
  assign o_inputs_out     = r_inputs_out;
  assign o_busy           = r_busy;
endmodule

// File: tb/tb_bnn_layer_sequencer.sv
module tb_bnn_layer_sequencer;
  localparam int NEURONS = 2;
  localparam int SETTLE  = 2;
  localparam int TOTAL   = NEURONS * 11;
  localparam int NBYTES  = (TOTAL + 7) / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bnn_layer_sequencer_if #(.NEURONS(NEURONS)) bus ();
  logic               setup, param_in, busy;
  logic [7:0]         inputs_out;
  logic [NEURONS-1:0] axons;

  bnn_layer_sequencer #(.NEURONS(NEURONS), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .o_setup      (setup),
    .o_param_in   (param_in),
    .o_inputs_out (inputs_out),
    .i_axons      (axons),
    .o_busy       (busy)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_rv  = 0;
  logic [7:0] cfg_bytes [0:NBYTES-1];

  // Monitor: logs every setup-high cycle (bit and cycle number), counts
  // result pulses, and notes the cycle cfg_done rises.
  int   cyc = 0;
  logic sbits [0:1023];
  int   scyc  [0:1023];
  int   stot = 0;
  int   rv_cnt = 0;
  int   done_rise = -1;
  logic done_q = 1'b0;
  int   overlap = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (setup && stot < 1024) begin
      sbits[stot] <= param_in;
      scyc[stot]  <= cyc;
      stot        <= stot + 1;
    end
    if (bus.result_valid) rv_cnt <= rv_cnt + 1;
    if (bus.cfg_done && !done_q) done_rise <= cyc;
    done_q <= bus.cfg_done;
    if (setup && bus.cfg_done) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_cfg(input int g);
    int snap, n;
    snap = stot;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    chk("start_rdy", bus.cfg_ready, 1);
    chk("start_done", bus.cfg_done, 0);
    chk("start_busy", busy, 1);
    for (int i = 0; i < NBYTES; i++) begin
      n = 0;
      while (!bus.cfg_ready && n < 50) begin tick(); n++; end
      chk("cfg_rdy_wait", bus.cfg_ready, 1);
      repeat (g) begin
        tick();
        chk("stall_setup", setup, 0);
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = cfg_bytes[i];
      tick();
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = 8'($urandom);
    end
    n = 0;
    while (!bus.cfg_done && n < 100) begin tick(); n++; end
    chk("cfg_done_wait", bus.cfg_done, 1);
    @(negedge clk); #1;
    chk("setup_cnt", stot - snap, TOTAL);
    for (int i = 0; i < TOTAL; i++)
      chk("param_bit", sbits[snap + i], cfg_bytes[i / 8][7 - (i % 8)]);
    chk("setup_span", scyc[snap + TOTAL - 1] - scyc[snap] + 1, TOTAL + (NBYTES - 1) * (1 + g));
    chk("done_edge", done_rise, scyc[snap + TOTAL - 1] + 1);
    tick();
    chk("ready_irdy", bus.infer_ready, 1);
    chk("ready_busy", busy, 0);
  endtask

  task automatic infer(input logic [7:0] d, input logic [NEURONS-1:0] a, input int gap,
                       input logic [NEURONS-1:0] prev);
    repeat (gap) begin
      axons = NEURONS'($urandom);
      tick();
      chk("gap_rv", bus.result_valid, 0);
      chk("gap_result_hold", bus.result, prev);
    end
    chk("irdy", bus.infer_ready, 1);
    bus.infer_valid = 1'b1;
    bus.infer_data  = d;
    tick();
    bus.infer_valid = 1'b0;
    bus.infer_data  = 8'($urandom);
    chk("inputs_out", inputs_out, d);
    chk("settle_irdy", bus.infer_ready, 0);
    chk("settle_busy", busy, 1);
    axons = ~a;
    for (int k = 1; k < SETTLE; k++) begin
      tick();
      chk("early_rv", bus.result_valid, 0);
      chk("settle_irdy", bus.infer_ready, 0);
    end
    axons = a;  // only the value present at the sampling edge may be captured
    tick();
    chk("rv", bus.result_valid, 1);
    chk("result", bus.result, a);
    chk("post_irdy", bus.infer_ready, 1);
    exp_rv++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int snap;
    logic [7:0] d;
    logic [NEURONS-1:0] a, last_a;
    bus.cfg_start   = 1'b0;
    bus.cfg_data    = 8'h00;
    bus.cfg_valid   = 1'b0;
    bus.infer_data  = 8'h00;
    bus.infer_valid = 1'b0;
    axons           = '0;
    repeat (2) tick();
    chk("rst_cfg_ready", bus.cfg_ready, 0);
    chk("rst_cfg_done", bus.cfg_done, 0);
    chk("rst_setup", setup, 0);
    chk("rst_param_in", param_in, 0);
    chk("rst_infer_ready", bus.infer_ready, 0);
    chk("rst_rv", bus.result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inputs_out", inputs_out, 0);
    chk("rst_result", bus.result, 0);
    rst_n = 1'b1;
    tick();

    // infer_valid while unconfigured is ignored
    bus.infer_valid = 1'b1;
    bus.infer_data  = 8'h5A;
    repeat (3) begin
      tick();
      chk("idle_irdy", bus.infer_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_inputs", inputs_out, 0);
    end
    bus.infer_valid = 1'b0;

    // fixed stream, no stalls
    cfg_bytes[0] = 8'hA5; cfg_bytes[1] = 8'h3C; cfg_bytes[2] = 8'hFF;
    do_cfg(0);

    // cfg_valid while READY is ignored
    snap = stot;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 8'h81;
    repeat (3) begin
      tick();
      chk("ready_cfg_rdy", bus.cfg_ready, 0);
      chk("ready_setup", setup, 0);
      chk("ready_irdy_hold", bus.infer_ready, 1);
      chk("ready_done_hold", bus.cfg_done, 1);
    end
    bus.cfg_valid = 1'b0;
    chk("ready_no_shift", stot - snap, 0);

    infer(8'hF0, 2'b10, 0, 2'b00);
    last_a = 2'b10;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      a = NEURONS'($urandom);
      infer(d, a, (i % 3 == 0) ? 0 : int'($urandom_range(1, 3)), last_a);
      last_a = a;
    end

    // restart during SETTLE_W drops the inference
    bus.infer_valid = 1'b1;
    bus.infer_data  = 8'hC3;
    tick();
    bus.infer_valid = 1'b0;
    chk("abort_inputs", inputs_out, 8'hC3);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    chk("abort_cfg_rdy", bus.cfg_ready, 1);
    chk("abort_done", bus.cfg_done, 0);
    chk("abort_rv", bus.result_valid, 0);
    chk("abort_irdy", bus.infer_ready, 0);
    repeat (SETTLE + 2) tick();
    chk("abort_inputs_hold", inputs_out, 8'hC3);
    chk("abort_load_wait", bus.cfg_ready, 1);

    // random stream with 5-cycle stalls before each byte
    for (int i = 0; i < NBYTES; i++) cfg_bytes[i] = 8'($urandom);
    do_cfg(5);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      a = NEURONS'($urandom);
      infer(d, a, int'($urandom_range(0, 2)), last_a);
      last_a = a;
    end

    // async reset in the middle of a shift
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 8'hFF;
    tick();
    bus.cfg_valid = 1'b0;
    repeat (2) tick();
    chk("pre_rst_setup", setup, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_setup", setup, 0);
    chk("arst_param_in", param_in, 0);
    chk("arst_cfg_ready", bus.cfg_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_inputs", inputs_out, 0);
    chk("arst_result", bus.result, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      chk("post_rst_setup", setup, 0);
      chk("post_rst_cfg_ready", bus.cfg_ready, 0);
      chk("post_rst_busy", busy, 0);
    end

    chk("overlap_done_setup", overlap, 0);
    chk("rv_pulses", rv_cnt, exp_rv);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
